vga_timing_gen: RTL and testbench

- Source end of the vga_if pipeline. Generates hcount, vcount, hsync, vsync, hblnk and vblnk for all downstream draw stages, which register and forward these signals unchanged.
- Drives rgb as constant zero; the draw stages fill the active area.
- Also emits single-cycle frame and line strobes for sprite, game-logic and frame-buffer blocks.
- Default timing is 800x600 @ 60 Hz at a 40 MHz pixel clock.

---
 rtl/vga_timing_gen_if.sv | 17 +
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_if: video bundle carried between the timing source and the draw stages.
//   vcount[10:0], vsync, vblnk : vertical position, sync and blanking
//   hcount[10:0], hsync, hblnk : horizontal position, sync and blanking
//   rgb[11:0]                  : pixel colour (4:4:4)
// Modport out drives the bundle; modport in receives it.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: source of the vga_if pipeline. Generates the pixel/line
// counters, sync pulses and blanking flags, plus single-cycle line/frame
// strobes. rgb is driven as constant zero.
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   en          advance enable; counters step only when 1
//   out         vga_if.out bundle (counts, syncs, blanks, rgb)
//   frame_start one-cycle pulse when the position wraps to (0,0)
//   line_start  one-cycle pulse when hcount wraps to 0
module vga_timing_gen #(
  parameter int unsigned HOR_PIXELS = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned VER_PIXELS = 600,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 23,
  parameter logic        SYNC_POL   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  vga_if.out   out,
  output logic frame_start,
  output logic line_start
);

  localparam int unsigned CW      = 11;
  localparam int unsigned DW      = CW + 1;
  localparam int unsigned H_TOTAL = HOR_PIXELS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = VER_PIXELS + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Decode boundaries held one bit wider so a sync end of 2048 stays exact.
  localparam logic [DW-1:0] H_ACT = DW'(HOR_PIXELS);
  localparam logic [DW-1:0] H_SB  = DW'(HOR_PIXELS + H_FP);
  localparam logic [DW-1:0] H_SE  = DW'(HOR_PIXELS + H_FP + H_SYNC);
  localparam logic [DW-1:0] V_ACT = DW'(VER_PIXELS);
  localparam logic [DW-1:0] V_SB  = DW'(VER_PIXELS + V_FP);
  localparam logic [DW-1:0] V_SE  = DW'(VER_PIXELS + V_FP + V_SYNC);

  // Counters are 11 bits wide; larger timings cannot be represented.
  if (H_TOTAL > 2048) begin : g_h_guard
    $error("vga_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 2048) begin : g_v_guard
    $error("vga_timing_gen: V_TOTAL exceeds 2048");
  end

  logic [CW-1:0] hcount_q, vcount_q;
  logic          hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic          frame_start_q, line_start_q;

  logic [CW-1:0] hcount_nxt, vcount_nxt;
  logic [DW-1:0] h_ext, v_ext;
  logic          h_wrap_c, f_wrap_c;
  logic          hsync_nxt, vsync_nxt, hblnk_nxt, vblnk_nxt;

  // Next position and its decode; flags derive from the _nxt counts so every
  // registered field describes the same pixel.
  always_comb begin
    hcount_nxt = hcount_q;
    vcount_nxt = vcount_q;
    h_wrap_c   = (hcount_q == H_LAST);
    f_wrap_c   = h_wrap_c && (vcount_q == V_LAST);

    if (h_wrap_c) begin
      hcount_nxt = '0;
      vcount_nxt = (vcount_q == V_LAST) ? '0 : vcount_q + CW'(1);
    end else begin
      hcount_nxt = hcount_q + CW'(1);
    end

    h_ext     = {1'b0, hcount_nxt};
    v_ext     = {1'b0, vcount_nxt};
    hblnk_nxt = (h_ext >= H_ACT);
    vblnk_nxt = (v_ext >= V_ACT);
    hsync_nxt = ((h_ext >= H_SB) && (h_ext < H_SE)) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt = ((v_ext >= V_SB) && (v_ext < V_SE)) ? SYNC_POL : ~SYNC_POL;
  end

  // Output registers; everything holds while en=0 except the strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else if (en) begin
      hcount_q      <= hcount_nxt;
      vcount_q      <= vcount_nxt;
      hblnk_q       <= hblnk_nxt;
      vblnk_q       <= vblnk_nxt;
      hsync_q       <= hsync_nxt;
      vsync_q       <= vsync_nxt;
      frame_start_q <= f_wrap_c;
      line_start_q  <= h_wrap_c;
    end else begin
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end
  end

  assign out.hcount  = hcount_q;
  assign out.vcount  = vcount_q;
  assign out.hsync   = hsync_q;
  assign out.vsync   = vsync_q;
  assign out.hblnk   = hblnk_q;
  assign out.vblnk   = vblnk_q;
  assign out.rgb     = 12'h000;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small timing positive sync,
// small timing negative sync, default 800x600) share clk/rst_n/en and are
// compared every cycle against a position model derived from the count of
// enabled steps since reset.
module tb_vga_timing_gen;

  logic clk, rst_n, en;
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: enabled steps since last reset, and whether the last edge stepped.
  int unsigned n       = 0;
  logic        stepped = 1'b0;

  vga_if vif_s ();
  vga_if vif_n ();
  vga_if vif_d ();
  logic fs_s, ls_s, fs_n, ls_n, fs_d, ls_d;

  vga_timing_gen #(
    .HOR_PIXELS(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .VER_PIXELS(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .out(vif_s),
    .frame_start(fs_s), .line_start(ls_s)
  );

  vga_timing_gen #(
    .HOR_PIXELS(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .VER_PIXELS(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .en(en), .out(vif_n),
    .frame_start(fs_n), .line_start(ls_n)
  );

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .en(en), .out(vif_d),
    .frame_start(fs_d), .line_start(ls_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected bundle for one instance from the raster index implied by n.
  task automatic check_dut(input string name,
                           input logic [10:0] hc, input logic [10:0] vc,
                           input logic hs, input logic vs, input logic hb, input logic vb,
                           input logic [11:0] rgb, input logic fs, input logic ls,
                           input int unsigned hp, input int unsigned hfp,
                           input int unsigned hsw, input int unsigned hbp,
                           input int unsigned vp, input int unsigned vfp,
                           input int unsigned vsw, input int unsigned vbp,
                           input logic pol);
    int unsigned ht, vt, idx, h, v;
    logic e_hs, e_vs;
    ht   = hp + hfp + hsw + hbp;
    vt   = vp + vfp + vsw + vbp;
    idx  = n % (ht * vt);
    h    = idx % ht;
    v    = idx / ht;
    e_hs = (h >= hp + hfp && h < hp + hfp + hsw) ? pol : ~pol;
    e_vs = (v >= vp + vfp && v < vp + vfp + vsw) ? pol : ~pol;
    check({name, ".hcount"},      32'(hc),  h);
    check({name, ".vcount"},      32'(vc),  v);
    check({name, ".hblnk"},       32'(hb),  32'(h >= hp));
    check({name, ".vblnk"},       32'(vb),  32'(v >= vp));
    check({name, ".hsync"},       32'(hs),  32'(e_hs));
    check({name, ".vsync"},       32'(vs),  32'(e_vs));
    check({name, ".rgb"},         32'(rgb), 32'(0));
    check({name, ".line_start"},  32'(ls),  32'(stepped && h == 0));
    check({name, ".frame_start"}, 32'(fs),  32'(stepped && idx == 0));
  endtask

  task automatic check_all();
    check_dut("s", vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk,
              vif_s.vblnk, vif_s.rgb, fs_s, ls_s, 16, 2, 3, 4, 6, 1, 2, 3, 1'b1);
    check_dut("n", vif_n.hcount, vif_n.vcount, vif_n.hsync, vif_n.vsync, vif_n.hblnk,
              vif_n.vblnk, vif_n.rgb, fs_n, ls_n, 16, 2, 3, 4, 6, 1, 2, 3, 1'b0);
    check_dut("d", vif_d.hcount, vif_d.vcount, vif_d.hsync, vif_d.vsync, vif_d.hblnk,
              vif_d.vblnk, vif_d.rgb, fs_d, ls_d, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1);
  endtask

  // One clock: drive en, sample 1 time unit after the edge, advance model, compare.
  task automatic cycle(input logic e);
    en = e;
    @(posedge clk);
    #1;
    stepped = e;
    if (e) n++;
    check_all();
  endtask

  int first_ls_d = -1;
  int first_fs_s = -1;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    #7;
    n = 0; stepped = 1'b0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset state held with en=0: no strobe.
    for (int i = 0; i < 3; i++) cycle(1'b0);

    // Continuous enable: covers several small frames and two default lines.
    for (int i = 1; i <= 2300; i++) begin
      cycle(1'b1);
      if (ls_d && first_ls_d < 0) first_ls_d = i;
      if (fs_s && first_fs_s < 0) first_fs_s = i;
    end
    check("first_line_start_d", 32'(first_ls_d), 32'(1056));
    check("first_frame_start_s", 32'(first_fs_s), 32'(300));

    // Enable toggling every cycle.
    for (int i = 0; i < 700; i++) cycle(1'(i % 2 == 0));

    // Random enable.
    for (int i = 0; i < 137; i++) cycle(1'($urandom_range(0, 3) != 0));

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst_n = 1'b0;
    #1;
    n = 0; stepped = 1'b0;
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) cycle(1'b0);

    // Random enable after restart, mostly enabled.
    for (int i = 0; i < 1500; i++) cycle(1'($urandom_range(0, 4) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
